ssg_multi: RTL

// Parametrised successor of the 3-channel SSG sound generator. It provides NCH square-wave tone

---
 rtl/ssg_multi.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ssg_multi.sv
// Multi-channel SSG sound generator: NCH tone channels, shared noise LFSR,
// shared 32-step envelope, per-channel stereo pan and registered L/R mixes.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   CE                    generator clock enable
//   WR, ADDR, WDATA       register write bus (one CLK per write)
//   RDATA                 combinational register readback for ADDR
//   MODE                  1 = AY 16-step volume table, 0 = YM 32-step table
//   CH_OUT                per-channel 8-bit level, channel k at [8k+7:8k]
//   MIX_L, MIX_R          full-width pan-weighted sums of the channel levels
//   ACTIVE                per-channel enable summary (tone or noise enabled)
module ssg_multi #(
   parameter int NCH      = 3,
   parameter int TONE_W   = 12,
   parameter int ENV_W    = 16,
   parameter int PRESCALE = 8,
   localparam int MW      = 12 + $clog2(NCH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CE,
   input  logic             WR,
   input  logic [5:0]       ADDR,
   input  logic [7:0]       WDATA,
   output logic [7:0]       RDATA,
   input  logic             MODE,
   output logic [8*NCH-1:0] CH_OUT,
   output logic [MW-1:0]    MIX_L,
   output logic [MW-1:0]    MIX_R,
   output logic [NCH-1:0]   ACTIVE
);

   localparam int PW = $clog2(PRESCALE);

   localparam logic [7:0] YM_TAB [0:31] = '{
      8'd0,   8'd1,   8'd1,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
      8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd12,  8'd14,  8'd16,
      8'd19,  8'd22,  8'd26,  8'd31,  8'd37,  8'd44,  8'd52,  8'd62,
      8'd74,  8'd88,  8'd104, 8'd124, 8'd147, 8'd175, 8'd208, 8'd255
   };

   localparam logic [7:0] AY_TAB [0:15] = '{
      8'd0,  8'd2,  8'd3,  8'd4,  8'd6,  8'd8,   8'd11,  8'd16,
      8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd180, 8'd255
   };

   typedef enum logic [1:0] {
      ENV_HOLD,
      ENV_UP,
      ENV_DN
   } env_st_t;

   // Register file
   logic [TONE_W-1:0] tone_per [NCH];
   logic [4:0]        vol      [NCH];
   logic [7:0]        pan      [NCH];
   logic [4:0]        noise_per;
   logic [NCH-1:0]    tone_dis;
   logic [NCH-1:0]    noise_dis;
   logic [ENV_W-1:0]  env_per;
   logic [3:0]        shape;

   // Generator state
   logic [PW-1:0]     pcnt;
   logic              nhalf;
   logic              tick;
   logic              noise_tick;
   logic [TONE_W-1:0] tone_cnt [NCH];
   logic [TONE_W-1:0] tone_lim [NCH];
   logic [NCH-1:0]    tone_op;
   logic [4:0]        noise_cnt;
   logic [4:0]        noise_lim;
   logic [16:0]       lfsr;
   logic [ENV_W-1:0]  env_cnt;
   logic [ENV_W-1:0]  env_lim;
   logic              env_wrap;
   logic              restart;
   env_st_t           env_st;
   env_st_t           env_st_n;
   logic [4:0]        env;
   logic [4:0]        env_n;
   logic              at_end;

   // Output path
   logic [8*NCH-1:0]  lvl_n;
   logic [MW-1:0]     mix_l_n;
   logic [MW-1:0]     mix_r_n;
   logic              gate;
   logic [4:0]        l5;
   logic [7:0]        lv;
   logic [11:0]       pl;
   logic [11:0]       pr;

   // Register writes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < NCH; k++) begin
            tone_per[k] <= '0;
            vol[k]      <= '0;
            pan[k]      <= 8'hFF;
         end
         noise_per <= '0;
         tone_dis  <= '1;
         noise_dis <= '1;
         env_per   <= '0;
         shape     <= '0;
      end else if (WR) begin
         for (int k = 0; k < NCH; k++) begin
            if (ADDR == 6'(2*k))
               tone_per[k][7:0] <= WDATA;
            if (ADDR == 6'(2*k+1))
               tone_per[k][TONE_W-1:8] <= WDATA[TONE_W-9:0];
            if (ADDR == 6'(24+k))
               vol[k] <= WDATA[4:0];
            if (ADDR == 6'(40+k))
               pan[k] <= WDATA;
         end
         case (ADDR)
            6'h10:   noise_per <= WDATA[4:0];
            6'h11:   tone_dis  <= WDATA[NCH-1:0];
            6'h12:   noise_dis <= WDATA[NCH-1:0];
            6'h20:   env_per[7:0] <= WDATA;
            6'h21:   env_per[ENV_W-1:8] <= WDATA[ENV_W-9:0];
            6'h22:   shape <= WDATA[3:0];
            default: ;
         endcase
      end
   end

   // Register readback
   always_comb begin
      RDATA = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ADDR == 6'(2*k))
            RDATA = tone_per[k][7:0];
         if (ADDR == 6'(2*k+1))
            RDATA = 8'(tone_per[k] >> 8);
         if (ADDR == 6'(24+k))
            RDATA = {3'b000, vol[k]};
         if (ADDR == 6'(40+k))
            RDATA = pan[k];
      end
      case (ADDR)
         6'h10:   RDATA = {3'b000, noise_per};
         6'h11:   RDATA = 8'(tone_dis);
         6'h12:   RDATA = 8'(noise_dis);
         6'h20:   RDATA = env_per[7:0];
         6'h21:   RDATA = 8'(env_per >> 8);
         6'h22:   RDATA = {4'b0000, shape};
         default: ;
      endcase
   end

   // Prescaler: tick on every PRESCALE-th CE, noise on every 2nd tick
   assign tick       = CE && (pcnt == PW'(PRESCALE-1));
   assign noise_tick = tick && nhalf;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pcnt  <= '0;
         nhalf <= 1'b0;
      end else if (CE) begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         if (tick)
            nhalf <= ~nhalf;
      end
   end

   // Period limits; a zero period behaves as one.
   // The >= compare lets a shortened period take effect without stalling.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         tone_lim[k] = (tone_per[k] == '0) ? '0 : tone_per[k] - TONE_W'(1);
      end
   end

   assign noise_lim = (noise_per == '0) ? '0 : noise_per - 5'd1;
   assign env_lim   = (env_per == '0) ? '0 : env_per - ENV_W'(1);

   // Tone counters
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < NCH; k++) begin
            tone_cnt[k] <= '0;
         end
         tone_op <= '0;
      end else if (tick) begin
         for (int k = 0; k < NCH; k++) begin
            if (tone_cnt[k] >= tone_lim[k]) begin
               tone_cnt[k] <= '0;
               tone_op[k]  <= ~tone_op[k];
            end else begin
               tone_cnt[k] <= tone_cnt[k] + TONE_W'(1);
            end
         end
      end
   end

   // Noise counter and LFSR
   always_ff @(posedge CLK) begin
      if (RESET) begin
         noise_cnt <= '0;
         lfsr      <= 17'h1;
      end else if (noise_tick) begin
         if (noise_cnt >= noise_lim) begin
            noise_cnt <= '0;
            lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
         end else begin
            noise_cnt <= noise_cnt + 5'd1;
         end
      end
   end

   // Envelope
   assign restart  = WR && (ADDR == 6'h22);
   assign env_wrap = tick && (env_cnt >= env_lim);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         env_cnt <= '0;
      end else if (restart) begin
         env_cnt <= '0;
      end else if (tick) begin
         env_cnt <= env_wrap ? '0 : env_cnt + ENV_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         env_st <= ENV_HOLD;
         env    <= '0;
      end else begin
         env_st <= env_st_n;
         env    <= env_n;
      end
   end

   // Restart uses the shape being written, so it wins over a same-cycle step.
   // Shape bits: [3]=C, [2]=At, [1]=Alt, [0]=H.
   always_comb begin
      env_st_n = env_st;
      env_n    = env;
      at_end   = ((env_st == ENV_UP) && (env == 5'd31)) ||
                 ((env_st == ENV_DN) && (env == 5'd0));
      if (restart) begin
         env_st_n = WDATA[2] ? ENV_UP : ENV_DN;
         env_n    = WDATA[2] ? 5'd0 : 5'd31;
      end else if (env_wrap) begin
         unique case (env_st)
            ENV_UP, ENV_DN: begin
               if (!at_end) begin
                  env_n = (env_st == ENV_UP) ? env + 5'd1 : env - 5'd1;
               end else if (!shape[3]) begin
                  env_n    = 5'd0;
                  env_st_n = ENV_HOLD;
               end else if (shape[0]) begin
                  env_n    = (shape[2] ^ shape[1]) ? 5'd31 : 5'd0;
                  env_st_n = ENV_HOLD;
               end else if (shape[1]) begin
                  // reverse; the end value is repeated once
                  env_st_n = (env_st == ENV_UP) ? ENV_DN : ENV_UP;
               end else begin
                  env_n = shape[2] ? 5'd0 : 5'd31;
               end
            end
            default: ;
         endcase
      end
   end

   // Channel levels and mixes
   always_comb begin
      lvl_n   = '0;
      mix_l_n = '0;
      mix_r_n = '0;
      gate    = 1'b0;
      l5      = '0;
      lv      = '0;
      pl      = '0;
      pr      = '0;
      for (int k = 0; k < NCH; k++) begin
         gate = (tone_dis[k] | tone_op[k]) & (noise_dis[k] | lfsr[0]);
         if (!gate)
            l5 = 5'd0;
         else if (vol[k][4])
            l5 = env;
         else
            l5 = {vol[k][3:0], vol[k][3]};
         lv = MODE ? AY_TAB[l5[4:1]] : YM_TAB[l5];
         lvl_n[8*k +: 8] = lv;
         pl = {4'b0000, lv} * {8'h00, pan[k][7:4]};
         pr = {4'b0000, lv} * {8'h00, pan[k][3:0]};
         mix_l_n = mix_l_n + MW'(pl);
         mix_r_n = mix_r_n + MW'(pr);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         CH_OUT <= '0;
         MIX_L  <= '0;
         MIX_R  <= '0;
      end else begin
         CH_OUT <= lvl_n;
         MIX_L  <= mix_l_n;
         MIX_R  <= mix_r_n;
      end
   end

   assign ACTIVE = ~(tone_dis & noise_dis);

endmodule
